// File: rtl/tt_um_cache_ctrl.sv
// -----------------------------------------------------------------------------
// tt_um_cache_ctrl
//
// This is a direct-mapped cache controller demo tile. It has an internal
// 16 x 4-bit backing memory and is wrapped in a TinyTapeout-style pin
// interface. The cache holds 4 lines of 4-bit data:
//   - index = addr[1:0]
//   - tag   = addr[3:2]
//   - one valid bit per line
//
// Write policy is write-through with no write-allocate. A read miss allocates
// the line. The fill is delayed by MISS_LATENCY cycles to emulate a slow
// backing memory.
//
// Ports
//   clk      : single clock; all state changes happen on its rising edge
//   rst_n    : asynchronous reset, ACTIVE-HIGH despite the name
//   ena      : 1 = new commands may be accepted. An op already in flight
//              always completes.
//   ui_in    : [1:0] cmd (00 NOP, 01 INVALIDATE, 10 READ, 11 WRITE)
//              [5:2] addr, [7:6] unused
//   uio_in   : [3:0] write data, [7:4] unused
//   uo_out   : [3:0] rdata, [4] hit, [5] miss, [6] busy, [7] rdata_valid
//   uio_out  : constant 8'h00
//   uio_oe   : constant 8'h00 (all uio pins are inputs)
//
// Every uo_out bit comes straight from a flop. There is no combinational
// path from ui_in to uo_out.
// -----------------------------------------------------------------------------
module tt_um_cache_ctrl #(
  parameter int MISS_LATENCY = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uo_out,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  localparam int CW = (MISS_LATENCY < 1) ? 1 : $clog2(MISS_LATENCY + 1);
  localparam logic [CW-1:0] MISS_CNT = CW'(MISS_LATENCY);

  localparam logic [1:0] CMD_NOP   = 2'b00;
  localparam logic [1:0] CMD_INV   = 2'b01;
  localparam logic [1:0] CMD_READ  = 2'b10;
  localparam logic [1:0] CMD_WRITE = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COMPARE = 2'd1,
    ST_FILL    = 2'd2,
    ST_DONE    = 2'd3
  } state_e;

  state_e state_q, state_d;

  // Latched command
  logic [1:0] cmd_q,   cmd_d;
  logic [3:0] addr_q,  addr_d;
  logic [3:0] wdata_q, wdata_d;

  // Cache arrays and backing memory
  logic [3:0] valid_q, valid_d;
  logic [1:0] tag_q  [4];
  logic [1:0] tag_d  [4];
  logic [3:0] line_q [4];
  logic [3:0] line_d [4];
  logic [3:0] mem_q  [16];
  logic [3:0] mem_d  [16];

  // Fill countdown
  logic [CW-1:0] cnt_q, cnt_d;

  // Registered status and data outputs
  logic [3:0] rdata_q, rdata_d;
  logic       hit_q,   hit_d;
  logic       miss_q,  miss_d;
  logic       busy_q,  busy_d;
  logic       rdv_q,   rdv_d;

  // Decoded inputs and lookup result
  logic [1:0] cmd_in_s;
  logic [3:0] addr_in_s;
  logic [3:0] wdata_in_s;
  logic       accept_s;
  logic [1:0] idx_s;
  logic [1:0] tag_s;
  logic       hit_s;
  logic       fill_last_s;
  logic       unused_s;

  assign cmd_in_s   = ui_in[1:0];
  assign addr_in_s  = ui_in[5:2];
  assign wdata_in_s = uio_in[3:0];
  assign accept_s   = ena && (cmd_in_s != CMD_NOP);

  // Lookup always uses the latched address, never the live pins.
  assign idx_s = addr_q[1:0];
  assign tag_s = addr_q[3:2];
  assign hit_s = valid_q[idx_s] && (tag_q[idx_s] == tag_s);

  // "<= 1" rather than "== 1" makes a corrupted zero count still leave
  // FILL instead of wrapping round for a full counter period.
  assign fill_last_s = (cnt_q <= CW'(1));

  // These pins are not used by this design.
  assign unused_s = ^{ui_in[7:6], uio_in[7:4]};

  assign uo_out  = {rdv_q, busy_q, miss_q, hit_q, rdata_q};
  assign uio_out = 8'h00;
  assign uio_oe  = 8'h00;

  // State register
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (accept_s) begin
          state_d = ST_COMPARE;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_COMPARE: begin
        if ((cmd_q == CMD_READ) && !hit_s) begin
          state_d = ST_FILL;
        end else begin
          state_d = ST_DONE;
        end
      end
      ST_FILL: begin
        if (fill_last_s) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_FILL;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Datapath and output next-state: command latch, cache/memory updates, status flags
  always_comb begin
    cmd_d   = cmd_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    valid_d = valid_q;
    tag_d   = tag_q;
    line_d  = line_q;
    mem_d   = mem_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    hit_d   = hit_q;
    miss_d  = miss_q;

    case (state_q)
      ST_IDLE: begin
        if (accept_s) begin
          cmd_d   = cmd_in_s;
          addr_d  = addr_in_s;
          wdata_d = wdata_in_s;
          hit_d   = 1'b0;
          miss_d  = 1'b0;
        end else begin
          cmd_d = cmd_q;
        end
      end

      ST_COMPARE: begin
        case (cmd_q)
          CMD_READ: begin
            if (hit_s) begin
              hit_d   = 1'b1;
              rdata_d = line_q[idx_s];
            end else begin
              miss_d = 1'b1;
              cnt_d  = MISS_CNT;
            end
          end
          CMD_WRITE: begin
            // Write-through: memory always takes the data. The cached copy
            // is only refreshed when the line already holds this address.
            mem_d[addr_q] = wdata_q;
            if (hit_s) begin
              line_d[idx_s] = wdata_q;
              hit_d         = 1'b1;
            end else begin
              miss_d = 1'b1;
            end
          end
          CMD_INV: begin
            valid_d = 4'b0000;
            hit_d   = 1'b0;
            miss_d  = 1'b0;
          end
          default: begin
            hit_d = hit_q;
          end
        endcase
      end

      ST_FILL: begin
        if (fill_last_s) begin
          cnt_d         = {CW{1'b0}};
          line_d[idx_s] = mem_q[addr_q];
          tag_d[idx_s]  = tag_s;
          valid_d       = valid_q | (4'b0001 << idx_s);
          rdata_d       = mem_q[addr_q];
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end

      ST_DONE: begin
        cnt_d = {CW{1'b0}};
      end

      default: begin
        cnt_d = {CW{1'b0}};
      end
    endcase

    // busy and rdata_valid are derived from the next state so that the
    // flopped copies line up exactly with the state register.
    busy_d = (state_d != ST_IDLE);
    rdv_d  = (state_d == ST_DONE) && (cmd_q == CMD_READ);
  end

  // Datapath registers. Reset also re-initialises the backing memory to mem[i] = i.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      cmd_q   <= CMD_NOP;
      addr_q  <= 4'h0;
      wdata_q <= 4'h0;
      valid_q <= 4'b0000;
      for (int i = 0; i < 4; i++) begin
        tag_q[i]  <= 2'b00;
        line_q[i] <= 4'h0;
      end
      for (int i = 0; i < 16; i++) begin
        mem_q[i] <= 4'(i);
      end
      cnt_q   <= {CW{1'b0}};
      rdata_q <= 4'h0;
      hit_q   <= 1'b0;
      miss_q  <= 1'b0;
      busy_q  <= 1'b0;
      rdv_q   <= 1'b0;
    end else begin
      cmd_q   <= cmd_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      valid_q <= valid_d;
      tag_q   <= tag_d;
      line_q  <= line_d;
      mem_q   <= mem_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      hit_q   <= hit_d;
      miss_q  <= miss_d;
      busy_q  <= busy_d;
      rdv_q   <= rdv_d;
    end
  end

endmodule

// File: tb/tb_tt_um_cache_ctrl.sv
// -----------------------------------------------------------------------------
// tb_tt_um_cache_ctrl
//
// Scoreboard bench for tt_um_cache_ctrl. Each issued command runs through a
// small reference model of the cache. The model produces an expected record
// and pushes it to a queue. A negedge monitor tracks each busy window. When
// busy falls, the monitor pops the record and compares the DONE-cycle
// outputs and the latency against it.
// -----------------------------------------------------------------------------
module tb_tt_um_cache_ctrl;

  localparam int ML = 2;

  logic       clk;
  logic       rst_n;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uio_in;
  logic [7:0] uo_out;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  tt_um_cache_ctrl #(.MISS_LATENCY(ML)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .ena     (ena),
    .ui_in   (ui_in),
    .uio_in  (uio_in),
    .uo_out  (uo_out),
    .uio_out (uio_out),
    .uio_oe  (uio_oe)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] rdata;
    logic       hit;
    logic       miss;
    logic       rdv;
    int         lat;
  } exp_t;

  exp_t sb[$];

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state
  logic [3:0] m_mem   [16];
  logic [3:0] m_line  [4];
  logic [1:0] m_tag   [4];
  logic [3:0] m_valid;
  logic [3:0] m_rdata;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) m_mem[i] = 4'(i);
    for (int i = 0; i < 4; i++) begin
      m_line[i] = 4'h0;
      m_tag[i]  = 2'b00;
    end
    m_valid = 4'b0000;
    m_rdata = 4'h0;
  endtask

  // Model the command, push its expectation, then drive it for one cycle
  task automatic issue(input logic [1:0] cmd, input logic [3:0] addr, input logic [3:0] wd);
    exp_t       e;
    logic [1:0] ix;
    logic [1:0] tg;
    logic       h;
    ix     = addr[1:0];
    tg     = addr[3:2];
    h      = m_valid[ix] && (m_tag[ix] == tg);
    e.hit  = 1'b0;
    e.miss = 1'b0;
    e.rdv  = 1'b0;
    e.lat  = 2;
    case (cmd)
      2'b10: begin
        e.rdv = 1'b1;
        if (h) begin
          e.hit   = 1'b1;
          m_rdata = m_line[ix];
        end else begin
          e.miss      = 1'b1;
          e.lat       = 2 + ML;
          m_line[ix]  = m_mem[addr];
          m_tag[ix]   = tg;
          m_valid[ix] = 1'b1;
          m_rdata     = m_mem[addr];
        end
      end
      2'b11: begin
        m_mem[addr] = wd;
        if (h) begin
          e.hit      = 1'b1;
          m_line[ix] = wd;
        end else begin
          e.miss = 1'b1;
        end
      end
      2'b01: m_valid = 4'b0000;
      default: ;
    endcase
    e.rdata = m_rdata;
    sb.push_back(e);
    @(negedge clk);
    ui_in  = {2'($urandom_range(0, 3)), addr, cmd};
    uio_in = {4'($urandom_range(0, 15)), wd};
    ena    = 1'b1;
    @(negedge clk);
    ui_in  = 8'h00;
    uio_in = 8'h00;
  endtask

  task automatic wait_idle();
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      #1;
      if (!uo_out[6]) break;
    end
    check_eq("idle_reached", 32'(uo_out[6]), 32'd0);
  endtask

  task automatic run_op(input logic [1:0] cmd, input logic [3:0] addr, input logic [3:0] wd);
    issue(cmd, addr, wd);
    wait_idle();
  endtask

  // Monitor: follow each busy window and score it when busy drops
  logic       busy_prev = 1'b0;
  int         cyc = 0;
  int         rdv_cnt = 0;
  logic [7:0] last_s = 8'h00;
  exp_t       mon_e;

  always @(negedge clk) begin
    if (rst_n) begin
      busy_prev = 1'b0;
    end else begin
      if (uo_out[6]) begin
        if (!busy_prev) begin
          cyc     = 1;
          rdv_cnt = 0;
          check_eq("accept_clr_hm", 32'(uo_out[5:4]), 32'd0);
        end else begin
          cyc++;
        end
        if (uo_out[7]) rdv_cnt++;
        last_s = uo_out;
      end else if (busy_prev) begin
        if (sb.size() == 0) begin
          check_eq("sb_underflow", 32'(sb.size()), 32'd1);
        end else begin
          mon_e = sb.pop_front();
          check_eq("done_rdata", 32'(last_s[3:0]), 32'(mon_e.rdata));
          check_eq("done_hit",   32'(last_s[4]),   32'(mon_e.hit));
          check_eq("done_miss",  32'(last_s[5]),   32'(mon_e.miss));
          check_eq("done_rdv",   32'(last_s[7]),   32'(mon_e.rdv));
          check_eq("rdv_cycles", 32'(rdv_cnt),     32'(mon_e.rdv));
          check_eq("latency",    32'(cyc),         32'(mon_e.lat));
          check_eq("rdv_end",    32'(uo_out[7]),   32'd0);
        end
      end
      busy_prev = uo_out[6];
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n  = 1'b1;
    ena    = 1'b1;
    ui_in  = 8'h00;
    uio_in = 8'h00;
    model_reset();
    repeat (3) @(negedge clk);
    #1;
    check_eq("reset_uo_out",  32'(uo_out),  32'h00);
    check_eq("reset_uio_out", 32'(uio_out), 32'h00);
    check_eq("reset_uio_oe",  32'(uio_oe),  32'h00);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);

    // Cold read miss, then the same read hits
    run_op(2'b10, 4'd5, 4'h0);
    run_op(2'b10, 4'd5, 4'h0);
    // Write miss does not allocate; later read fills the written value
    run_op(2'b11, 4'd2, 4'h0);
    run_op(2'b10, 4'd2, 4'h0);
    // Write hit updates the line; a conflicting tag evicts it
    run_op(2'b11, 4'd5, 4'hA);
    run_op(2'b10, 4'd5, 4'h0);
    run_op(2'b10, 4'd9, 4'h0);
    run_op(2'b10, 4'd5, 4'h0);
    // Invalidate, then a previously cached address misses
    run_op(2'b01, 4'd0, 4'h0);
    run_op(2'b10, 4'd5, 4'h0);

    // A write pulsed during a fill must be dropped
    run_op(2'b01, 4'd0, 4'h0);
    issue(2'b10, 4'd3, 4'h0);
    @(negedge clk);
    ui_in  = {2'b00, 4'd3, 2'b11};
    uio_in = 8'h0F;
    @(negedge clk);
    ui_in  = 8'h00;
    uio_in = 8'h00;
    wait_idle();
    run_op(2'b01, 4'd0, 4'h0);
    run_op(2'b10, 4'd3, 4'h0);

    // A command with ena=0 must be dropped
    @(negedge clk);
    ui_in  = {2'b00, 4'd7, 2'b11};
    uio_in = 8'h01;
    ena    = 1'b0;
    @(negedge clk);
    #1;
    check_eq("ena0_not_busy", 32'(uo_out[6]), 32'd0);
    ui_in  = 8'h00;
    uio_in = 8'h00;
    ena    = 1'b1;
    run_op(2'b10, 4'd7, 4'h0);

    // Random mix of commands
    for (int n = 0; n < 40; n++) begin
      int r;
      logic [1:0] c;
      r = int'($urandom_range(0, 9));
      c = (r < 1) ? 2'b01 : ((r < 5) ? 2'b11 : 2'b10);
      run_op(c, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
    end

    // Reset in the middle of a fill after dirtying memory
    run_op(2'b11, 4'd6, 4'hC);
    run_op(2'b01, 4'd0, 4'h0);
    issue(2'b10, 4'd6, 4'h0);
    @(negedge clk);
    #2;
    rst_n = 1'b1;
    #1;
    check_eq("midfill_reset_uo_out", 32'(uo_out), 32'h00);
    sb.delete();
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    run_op(2'b10, 4'd6, 4'h0);
    run_op(2'b10, 4'd5, 4'h0);
    run_op(2'b10, 4'd5, 4'h0);

    repeat (2) @(negedge clk);
    check_eq("sb_drained", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
